button_to_dist: RTL and testbench

- Converts the debounced jump button into a jump distance for the game FSM.
- While the button is held, a charge counter grows at a fixed prescaled rate. On release, the charged value is presented on jump_dist for a fixed hold window, with a one-cycle end_of_jump strobe.
- Sits between the jump-button debouncer and the game FSM. The hold window lets the FSM, running on the slower render clock, sample the distance reliably.

---
 rtl/button_to_dist.sv | 123 ++++++++++++
 tb/tb_button_to_dist.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_to_dist.sv
// button_to_dist
// Converts the debounced jump button level into a jump distance for the
// game FSM. Holding the button charges a saturating 8-bit count at one unit
// per TICK_DIV clocks. On release the count is presented on jump_dist for
// HOLD_CYCLES clocks, with a one-cycle end_of_jump strobe on the first of
// those cycles, so that the slower render-clock FSM can sample it safely.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no jump pending, jump_dist = 0, waiting for a press
// S_CHARGE   | button held, prescaler running, count growing to MAX_DIST
// S_HOLD     | jump_dist = captured count for HOLD_CYCLES clocks
// S_WAIT_REL | hold window over but button still down; wait for release

module button_to_dist #(
  parameter int TICK_DIV    = 1000000,
  parameter int HOLD_CYCLES = 2000000,
  parameter int MAX_DIST    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       jump_btn,
  output logic [7:0] jump_dist,
  output logic       end_of_jump
);

  // Prescaler must hold TICK_DIV-1; keep at least one bit when TICK_DIV = 1.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Hold counter must hold HOLD_CYCLES.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0]    MAX_D     = MAX_DIST[7:0];

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHARGE   = 2'd1,
    S_HOLD     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_count;
  logic [7:0]    r_dist;
  logic          r_eoj;

  // Sequencing FSM with all counters and outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_hold  <= '0;
      r_count <= '0;
      r_dist  <= '0;
      r_eoj   <= 1'b0;
    end else begin
      // The strobe is only ever raised for the single cycle entering S_HOLD.
      r_eoj <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dist <= '0;
          if (jump_btn) begin
            r_state <= S_CHARGE;
            r_count <= '0;
            r_presc <= '0;
          end
        end

        S_CHARGE: begin
          if (jump_btn) begin
            if (r_presc == PRE_LAST) begin
              r_presc <= '0;
              // Saturate rather than wrap so a long press never looks short.
              if (r_count < MAX_D) begin
                r_count <= r_count + 8'd1;
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end else if (r_count != 8'd0) begin
            r_dist  <= r_count;
            r_eoj   <= 1'b1;
            r_hold  <= '0;
            r_state <= S_HOLD;
          end else begin
            // Tap too short to earn a unit: no jump, no strobe.
            r_state <= S_IDLE;
          end
        end

        S_HOLD: begin
          // Presses here are ignored; a fresh charge needs a new 0->1 edge.
          if (r_hold == HOLD_LAST) begin
            r_dist  <= '0;
            r_hold  <= '0;
            r_state <= jump_btn ? S_WAIT_REL : S_IDLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end

        S_WAIT_REL: begin
          r_dist <= '0;
          if (!jump_btn) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_dist  <= '0;
        end
      endcase
    end
  end

  assign jump_dist   = r_dist;
  assign end_of_jump = r_eoj;

endmodule

// File: tb/tb_button_to_dist.sv
// Directed bench for button_to_dist. Two instances share clock and reset:
// dut_a uses MAX_DIST=255, dut_b uses MAX_DIST=5 for the saturation case.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_button_to_dist;

  logic       clk;
  logic       rst_n;
  logic       btn_a;
  logic       btn_b;
  logic [7:0] dist_a;
  logic [7:0] dist_b;
  logic       eoj_a;
  logic       eoj_b;

  int n_checks = 0;
  int n_fail   = 0;

  button_to_dist #(.TICK_DIV(4), .HOLD_CYCLES(8), .MAX_DIST(255)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_btn    (btn_a),
    .jump_dist   (dist_a),
    .end_of_jump (eoj_a)
  );

  button_to_dist #(.TICK_DIV(4), .HOLD_CYCLES(8), .MAX_DIST(5)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .jump_btn    (btn_b),
    .jump_dist   (dist_b),
    .end_of_jump (eoj_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int strobes;
  int nonzero;

  initial begin
    rst_n = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;

    // Reset held with the button toggling: outputs stay quiet.
    for (int i = 0; i < 3; i++) begin
      btn_a = ~btn_a;
      tick(1);
      chk("rst_dist", int'(dist_a), 0);
      chk("rst_eoj", int'(eoj_a), 0);
    end
    btn_a = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Post-reset state is IDLE with cleared counters: 5-clk press gives 1.
    btn_a = 1'b1;
    tick(5);
    btn_a = 1'b0;
    tick(1);
    chk("post_rst_dist", int'(dist_a), 1);
    chk("post_rst_eoj", int'(eoj_a), 1);
    tick(12);

    // Normal jump: 41 clk held -> 10 units, valid 8 clk, one strobe.
    btn_a = 1'b1;
    tick(41);
    chk("charge_dist_zero", int'(dist_a), 0);
    btn_a = 1'b0;
    tick(1);
    chk("norm_dist_first", int'(dist_a), 10);
    chk("norm_eoj_first", int'(eoj_a), 1);
    strobes = 0;
    nonzero = 1;
    for (int i = 1; i < 8; i++) begin
      tick(1);
      if (dist_a == 8'd10) nonzero++;
      if (eoj_a) strobes++;
    end
    chk("norm_valid_cycles", nonzero, 8);
    chk("norm_extra_strobes", strobes, 0);
    tick(1);
    chk("norm_dist_after", int'(dist_a), 0);
    chk("norm_eoj_after", int'(eoj_a), 0);
    tick(3);

    // Tap of 2 clk: no strobe, distance stays 0.
    btn_a = 1'b1;
    tick(2);
    btn_a = 1'b0;
    strobes = 0;
    nonzero = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (eoj_a) strobes++;
      if (dist_a != 8'd0) nonzero++;
    end
    chk("tap_strobes", strobes, 0);
    chk("tap_nonzero", nonzero, 0);

    // Saturation at MAX_DIST=5: 100 clk held, single strobe.
    btn_b = 1'b1;
    tick(100);
    btn_b = 1'b0;
    tick(1);
    chk("sat5_dist", int'(dist_b), 5);
    strobes = int'(eoj_b);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (eoj_b) strobes++;
    end
    chk("sat5_strobes", strobes, 1);
    chk("sat5_dist_after", int'(dist_b), 0);

    // Saturation at 255 without wrap-around: 1100 clk held.
    btn_a = 1'b1;
    tick(1100);
    btn_a = 1'b0;
    tick(1);
    chk("sat255_dist", int'(dist_a), 255);
    chk("sat255_eoj", int'(eoj_a), 1);
    tick(10);

    // Held through the hold window: re-press in HOLD is ignored.
    btn_a = 1'b1;
    tick(21);
    btn_a = 1'b0;
    tick(1);
    chk("held_dist_first", int'(dist_a), 5);
    chk("held_eoj_first", int'(eoj_a), 1);
    btn_a = 1'b1;
    tick(7);
    chk("held_dist_last", int'(dist_a), 5);
    tick(1);
    chk("held_dist_end", int'(dist_a), 0);
    strobes = 0;
    nonzero = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (eoj_a) strobes++;
      if (dist_a != 8'd0) nonzero++;
    end
    chk("held_no_strobe", strobes, 0);
    chk("held_no_dist", nonzero, 0);
    btn_a = 1'b0;
    tick(1);
    btn_a = 1'b1;
    tick(5);
    btn_a = 1'b0;
    tick(1);
    chk("held_recharge_dist", int'(dist_a), 1);
    chk("held_recharge_eoj", int'(eoj_a), 1);
    tick(10);

    // Async reset mid-HOLD: outputs clear before the next edge.
    btn_a = 1'b1;
    tick(9);
    btn_a = 1'b0;
    tick(1);
    chk("ar_dist_pre", int'(dist_a), 2);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_dist_now", int'(dist_a), 0);
    chk("ar_eoj_now", int'(eoj_a), 0);
    tick(1);
    rst_n = 1'b1;
    strobes = 0;
    nonzero = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (eoj_a) strobes++;
      if (dist_a != 8'd0) nonzero++;
    end
    chk("ar_no_strobe", strobes, 0);
    chk("ar_no_dist", nonzero, 0);
    btn_a = 1'b1;
    tick(5);
    btn_a = 1'b0;
    tick(1);
    chk("ar_idle_dist", int'(dist_a), 1);
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
